// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - single-outstanding SRAM responder with fixed latency and byte-masked writes
module sram_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam logic [7:0]  LAT8  = 8'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             acc_wen;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_wmask;
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             unused_wmask_hi;

  assign unused_wmask_hi = ^req_wmask[7:4];

  // With LATENCY=0 the access happens at the accepting edge, so use the live request.
  always_comb begin
    accept     = (state_q == IDLE) && req_valid && req_ready_q;
    enter_resp = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 8'd1));
    if (state_q == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask[3:0];
    end else begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
    offset   = acc_addr - BASE_ADDR;
    in_range = (acc_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    idx      = offset[IDX_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wmask[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wen_q       <= req_wen;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wmask_q     <= req_wmask[3:0];
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT8;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        err_q        <= !in_range;
        rdata_q      <= (in_range && !acc_wen) ? mem[idx] : 32'd0;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
